led_pwm_fader: RTL and testbench

//   Downstream stage of the LED blinker. Takes the two hard on/off LED requests and turns each into
//   a PWM-driven LED that ramps brightness up and down linearly instead of switching abruptly.

---
 rtl/led_pwm_fader.sv | 138 +++++++++++++
 tb/tb_led_pwm_fader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// LED PWM fader: turns two on/off LED requests into PWM drives whose brightness ramps linearly.
// Both channels share one brightness-step prescaler and one free-running PWM counter.
module led_pwm_fader #(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned STEP_DIV = 195312
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                enable,
   input  logic                led_req_1,
   input  logic                led_req_2,
   output logic                led_pwm_1,
   output logic                led_pwm_2,
   output logic [PWM_BITS-1:0] level_1,
   output logic [PWM_BITS-1:0] level_2,
   output logic                busy
);

   localparam int                  N_CH     = 2;
   localparam int unsigned         PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] LMAX     = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      OFF,
      RAMP_UP,
      ON,
      RAMP_DOWN
   } fade_state_t;

   logic [PRE_W-1:0]    presc;
   logic                step_tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [N_CH-1:0]     req_in;
   logic [N_CH-1:0]     req_q;
   logic [N_CH-1:0]     pwm_q;
   logic [PWM_BITS-1:0] lvl [N_CH];
   fade_state_t         st  [N_CH];

   assign req_in = {led_req_2, led_req_1};

   // Direction the channel heads in this cycle, given the registered request.
   function automatic fade_state_t steer(input fade_state_t s, input logic req);
      case (s)
         OFF:     return req ? RAMP_UP : OFF;
         ON:      return req ? ON : RAMP_DOWN;
         default: return req ? RAMP_UP : RAMP_DOWN;
      endcase
   endfunction

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         presc <= '0;
      end else if (!enable || presc == PRE_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   assign step_tick = enable && (presc == PRE_LAST);

   // PWM period is LMAX cycles so that level LMAX yields a constant high.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == LMAX - ONE) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + ONE;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         req_q <= '0;
         pwm_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            st[i]  <= OFF;
            lvl[i] <= '0;
         end
      end else begin
         req_q <= req_in;
         for (int i = 0; i < N_CH; i++) begin
            if (!enable) begin
               st[i]    <= OFF;
               lvl[i]   <= '0;
               pwm_q[i] <= 1'b0;
            end else begin
               pwm_q[i] <= (lvl[i] > pwm_cnt);
               // A reversal takes effect this cycle; a coincident tick steps the new way.
               case (steer(st[i], req_q[i]))
                  RAMP_UP: begin
                     if (step_tick && lvl[i] >= LMAX - ONE) begin
                        lvl[i] <= LMAX;
                        st[i]  <= ON;
                     end else begin
                        st[i] <= RAMP_UP;
                        if (step_tick) lvl[i] <= lvl[i] + ONE;
                     end
                  end
                  RAMP_DOWN: begin
                     if (step_tick && lvl[i] <= ONE) begin
                        lvl[i] <= '0;
                        st[i]  <= OFF;
                     end else begin
                        st[i] <= RAMP_DOWN;
                        if (step_tick) lvl[i] <= lvl[i] - ONE;
                     end
                  end
                  ON: begin
                     st[i]  <= ON;
                     lvl[i] <= LMAX;
                  end
                  default: begin
                     st[i]  <= OFF;
                     lvl[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (st[i] == RAMP_UP || st[i] == RAMP_DOWN) busy = 1'b1;
      end
   end

   assign led_pwm_1 = pwm_q[0];
   assign led_pwm_2 = pwm_q[1];
   assign level_1   = lvl[0];
   assign level_2   = lvl[1];

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: directed scenarios plus random requests/enable/reset,
// checked every cycle against a goal-seeking brightness model.
module tb_led_pwm_fader;

   localparam int PWM_BITS = 4;
   localparam int STEP_DIV = 4;
   localparam int LMAX     = 15;

   logic                sys_clk = 1'b0;
   logic                sys_rst;
   logic                enable;
   logic                led_req_1;
   logic                led_req_2;
   logic                led_pwm_1;
   logic                led_pwm_2;
   logic [PWM_BITS-1:0] level_1;
   logic [PWM_BITS-1:0] level_2;
   logic                busy;

   int n_checks = 0;
   int n_errors = 0;

   // Model: each channel seeks a goal (0 or LMAX) set by the delayed request,
   // one unit per step tick; it is "settled" once a tick lands it on the goal.
   int m_lvl     [2];
   bit m_settled [2];
   bit m_goal_up [2];
   bit m_req_q   [2];
   bit m_pwm     [2];
   int m_cyc;
   int m_en_cyc;

   led_pwm_fader #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .enable    (enable),
      .led_req_1 (led_req_1),
      .led_req_2 (led_req_2),
      .led_pwm_1 (led_pwm_1),
      .led_pwm_2 (led_pwm_2),
      .level_1   (level_1),
      .level_2   (level_2),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_lvl[c] = 0; m_settled[c] = 1'b1; m_goal_up[c] = 1'b0;
         m_req_q[c] = 1'b0; m_pwm[c] = 1'b0;
      end
      m_cyc = 0;
      m_en_cyc = 0;
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_edge();
      bit tick;
      int pcnt;
      bit req [2];
      req[0] = led_req_1;
      req[1] = led_req_2;
      tick = enable && ((m_en_cyc % STEP_DIV) == STEP_DIV - 1);
      pcnt = m_cyc % LMAX;
      for (int c = 0; c < 2; c++) begin
         m_pwm[c] = enable && (m_lvl[c] > pcnt);
         if (!enable) begin
            m_lvl[c] = 0; m_settled[c] = 1'b1; m_goal_up[c] = 1'b0;
         end else begin
            if (m_req_q[c] != m_goal_up[c]) begin
               m_goal_up[c] = m_req_q[c];
               m_settled[c] = 1'b0;
            end
            if (tick && !m_settled[c]) begin
               if (m_goal_up[c]) m_lvl[c] = (m_lvl[c] + 1 > LMAX) ? LMAX : m_lvl[c] + 1;
               else              m_lvl[c] = (m_lvl[c] - 1 < 0) ? 0 : m_lvl[c] - 1;
               if (m_lvl[c] == (m_goal_up[c] ? LMAX : 0)) m_settled[c] = 1'b1;
            end
         end
         m_req_q[c] = req[c];
      end
      m_cyc++;
      m_en_cyc = enable ? m_en_cyc + 1 : 0;
   endtask

   task automatic compare_all();
      check("level_1", int'(level_1), m_lvl[0]);
      check("level_2", int'(level_2), m_lvl[1]);
      check("led_pwm_1", int'(led_pwm_1), int'(m_pwm[0]));
      check("led_pwm_2", int'(led_pwm_2), int'(m_pwm[1]));
      check("busy", int'(busy), int'(!m_settled[0] || !m_settled[1]));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge sys_clk);
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Bounded wait for channel 1 to reach a level; a timeout shows up as a failed check.
   task automatic wait_level_1(input int target);
      for (int k = 0; k < 200; k++) begin
         if (int'(level_1) == target) break;
         cycle();
      end
      check("reach_level_1", int'(level_1), target);
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_level_1"}, int'(level_1), 0);
      check({tag, "_level_2"}, int'(level_2), 0);
      check({tag, "_pwm_1"}, int'(led_pwm_1), 0);
      check({tag, "_pwm_2"}, int'(led_pwm_2), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   int highs;

   initial begin
      sys_rst = 1'b1; enable = 1'b1; led_req_1 = 1'b1; led_req_2 = 1'b1;
      model_reset();

      // Held in reset with requests high: everything stays dark.
      for (int k = 0; k < 5; k++) begin
         @(posedge sys_clk);
         #1;
         check_dark("in_reset");
      end
      sys_rst = 1'b0;
      led_req_2 = 1'b0;

      // Full ramp up on channel 1 while channel 2 stays dark.
      run(72);
      check("ramp_top", int'(level_1), LMAX);
      check("ramp_idle", int'(busy), 0);
      check("ch2_dark", int'(level_2), 0);
      highs = 0;
      for (int k = 0; k < LMAX; k++) begin
         cycle();
         highs += int'(led_pwm_1);
      end
      check("duty_full", highs, LMAX);

      // Ramp back to zero, then confirm the output never pulses.
      led_req_1 = 1'b0;
      run(72);
      check("ramp_bottom", int'(level_1), 0);
      highs = 0;
      for (int k = 0; k < LMAX; k++) begin
         cycle();
         highs += int'(led_pwm_1);
      end
      check("duty_zero", highs, 0);

      // Reverse at level 7: descend without a jump.
      led_req_1 = 1'b1;
      wait_level_1(7);
      led_req_1 = 1'b0;
      run(40);
      check("reversal_off", int'(level_1), 0);
      check("reversal_busy", int'(busy), 0);

      // Enable drop at level 9, then restart from 0.
      led_req_1 = 1'b1;
      wait_level_1(9);
      enable = 1'b0;
      cycle();
      check_dark("enable_drop");
      run(3);
      enable = 1'b1;
      run(12);
      check("restart_low", int'(level_1 <= 4'd3), 1);
      run(60);

      // Randomized requests, enable drops and asynchronous resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) led_req_1 = ~led_req_1;
         if ($urandom_range(0, 7) == 0) led_req_2 = ~led_req_2;
         if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         if ($urandom_range(0, 499) == 0) begin
            sys_rst = 1'b1;
            #1;
            check_dark("async_rst");
            model_reset();
            @(posedge sys_clk);
            #1;
            check_dark("rst_hold");
            sys_rst = 1'b0;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
